// File: rtl/transform_butterfly_pipe.sv
// transform_butterfly_pipe: two-stage, valid/ready flow-controlled 4-point butterfly.
// Each beat carries ROWS independent 4-element rows plus a mode:
// inverse core (00/11), Hadamard (01) or forward core (10).
// Optional macro BUTTERFLY_SAT_EN: clamp stage-2 results to the signed DW range.

// Per-row arithmetic: stage-1 butterfly on incoming x, stage-2 butterfly on registered e.
module transform_butterfly_row #(
  parameter int DW = 16
) (
  input  logic [1:0]            s1_mode,
  input  logic [3:0][DW-1:0]    x,
  output logic [3:0][DW+1:0]    e,
  input  logic [1:0]            s2_mode,
  input  logic [3:0][DW+1:0]    e_in,
  output logic [3:0][DW+2:0]    y
);
  localparam int EW = DW + 2;
  localparam int OW = DW + 3;

`ifdef BUTTERFLY_SAT_EN
  localparam logic signed [OW-1:0] SAT_MAX = {4'b0000, {(DW-1){1'b1}}};
  localparam logic signed [OW-1:0] SAT_MIN = {4'b1111, {(DW-1){1'b0}}};

  function automatic logic [OW-1:0] clamp(input logic signed [OW-1:0] v);
    if (v > SAT_MAX)      clamp = SAT_MAX;
    else if (v < SAT_MIN) clamp = SAT_MIN;
    else                  clamp = v;
  endfunction
`endif

  logic signed [EW-1:0] x0, x1, x2, x3;
  logic signed [EW-1:0] e0, e1, e2, e3;
  logic signed [OW-1:0] w0, w1, w2, w3;
  logic signed [OW-1:0] y0, y1, y2, y3;

  // Stage 1: sign-extend inputs, then mode-dependent first butterfly
  always_comb begin
    x0 = {{2{x[0][DW-1]}}, x[0]};
    x1 = {{2{x[1][DW-1]}}, x[1]};
    x2 = {{2{x[2][DW-1]}}, x[2]};
    x3 = {{2{x[3][DW-1]}}, x[3]};
    case (s1_mode)
      2'b01: begin
        e0 = x0 + x2;
        e1 = x0 - x2;
        e2 = x1 - x3;
        e3 = x1 + x3;
      end
      2'b10: begin
        e0 = x0 + x3;
        e1 = x1 + x2;
        e2 = x1 - x2;
        e3 = x0 - x3;
      end
      default: begin
        e0 = x0 + x2;
        e1 = x0 - x2;
        e2 = (x1 >>> 1) - x3;
        e3 = x1 + (x3 >>> 1);
      end
    endcase
    e = {e3, e2, e1, e0};
  end

  // Stage 2: second butterfly on the registered stage-1 values
  always_comb begin
    w0 = {e_in[0][EW-1], e_in[0]};
    w1 = {e_in[1][EW-1], e_in[1]};
    w2 = {e_in[2][EW-1], e_in[2]};
    w3 = {e_in[3][EW-1], e_in[3]};
    if (s2_mode == 2'b10) begin
      y0 = w0 + w1;
      y1 = (w3 <<< 1) + w2;
      y2 = w0 - w1;
      y3 = w3 - (w2 <<< 1);
    end else begin
      y0 = w0 + w3;
      y1 = w1 + w2;
      y2 = w1 - w2;
      y3 = w0 - w3;
    end
`ifdef BUTTERFLY_SAT_EN
    y = {clamp(y3), clamp(y2), clamp(y1), clamp(y0)};
`else
    y = {y3, y2, y1, y0};
`endif
  end
endmodule

module transform_butterfly_pipe #(
  parameter int DW    = 16,
  parameter int ROWS  = 4,
  parameter int TAG_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  in_mode,
  input  logic [TAG_W-1:0]            in_tag,
  input  logic [ROWS*4*DW-1:0]        in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TAG_W-1:0]            out_tag,
  output logic [ROWS*4*(DW+3)-1:0]    out_data
);
  localparam int EW = DW + 2;
  localparam int OW = DW + 3;

  logic [ROWS-1:0][3:0][DW-1:0] in_x;
  logic [ROWS-1:0][3:0][EW-1:0] e_nxt, s1_e_d, s1_e_q;
  logic [ROWS-1:0][3:0][OW-1:0] y_nxt, s2_y_d, s2_y_q;
  logic [2:1]                   vld_pipe_d, vld_pipe_q;
  logic [1:0]                   s1_mode_d, s1_mode_q;
  logic [TAG_W-1:0]             s1_tag_d, s1_tag_q, s2_tag_d, s2_tag_q;
  logic                         s1_adv, s2_adv;

  assign in_x = in_data;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    transform_butterfly_row #(.DW(DW)) u_row (
      .s1_mode (in_mode),
      .x       (in_x[r]),
      .e       (e_nxt[r]),
      .s2_mode (s1_mode_q),
      .e_in    (s1_e_q[r]),
      .y       (y_nxt[r])
    );
  end

  // Advance conditions; no skid buffer, so in_ready follows out_ready combinationally
  always_comb begin
    s2_adv = !vld_pipe_q[2] || out_ready;
    s1_adv = !vld_pipe_q[1] || s2_adv;
  end

  assign in_ready  = s1_adv;
  assign out_valid = vld_pipe_q[2];
  assign out_tag   = s2_tag_q;
  assign out_data  = s2_y_q;

  // Next-state: data regs load only on advance with a valid beat, bubbles keep old data
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_e_d     = s1_e_q;
    s1_mode_d  = s1_mode_q;
    s1_tag_d   = s1_tag_q;
    s2_y_d     = s2_y_q;
    s2_tag_d   = s2_tag_q;
    if (s1_adv) begin
      vld_pipe_d[1] = in_valid;
      if (in_valid) begin
        s1_e_d    = e_nxt;
        s1_mode_d = in_mode;
        s1_tag_d  = in_tag;
      end
    end
    if (s2_adv) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[1]) begin
        s2_y_d   = y_nxt;
        s2_tag_d = s1_tag_q;
      end
    end
  end

  // Pipeline registers with synchronous reset discarding in-flight beats
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_e_q     <= '0;
      s1_mode_q  <= '0;
      s1_tag_q   <= '0;
      s2_y_q     <= '0;
      s2_tag_q   <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_e_q     <= s1_e_d;
      s1_mode_q  <= s1_mode_d;
      s1_tag_q   <= s1_tag_d;
      s2_y_q     <= s2_y_d;
      s2_tag_q   <= s2_tag_d;
    end
  end
endmodule

// File: tb/tb_transform_butterfly_pipe.sv
// Self-checking bench for transform_butterfly_pipe (ROWS=4 instance plus a ROWS=1
// instance fed with row 0 of the same stimulus). Honours BUTTERFLY_SAT_EN.
module tb_transform_butterfly_pipe;
  localparam int DW = 16;
  localparam int TW = 4;
  localparam int R  = 4;
  localparam int OW = DW + 3;
  localparam int IW = R * 4 * DW;
  localparam int XW = R * 4 * OW;

  typedef struct {
    logic [TW-1:0] tag;
    logic [XW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_ready1;
  logic [1:0]    in_mode;
  logic [TW-1:0] in_tag;
  logic [IW-1:0] in_data;
  logic          out_valid, out_valid1, out_ready;
  logic [TW-1:0] out_tag, out_tag1;
  logic [XW-1:0] out_data;
  logic [4*OW-1:0] out_data1;

  int checks = 0;
  int failures = 0;
  beat_t sb[$];

  bit            s_acc, s_emit, s_valid, s_valid1, s_ready, s_ready1;
  logic [XW-1:0] s_data;
  logic [4*OW-1:0] s_data1;
  logic [TW-1:0] s_tag, s_tag1;

  always #5 clk = ~clk;

  transform_butterfly_pipe #(.DW(DW), .ROWS(R), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_tag(in_tag), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_data(out_data));

  transform_butterfly_pipe #(.DW(DW), .ROWS(1), .TAG_W(TW)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_mode(in_mode),
    .in_tag(in_tag), .in_data(in_data[4*DW-1:0]), .out_valid(out_valid1), .out_ready(out_ready),
    .out_tag(out_tag1), .out_data(out_data1));

  // Reference model for one row, straight from the butterfly equations
  function automatic logic [4*OW-1:0] model_row(input logic [1:0] m, input logic [4*DW-1:0] xin);
    int x[4];
    int e[4];
    int y[4];
    int t;
    logic [4*OW-1:0] r;
    for (int k = 0; k < 4; k++) x[k] = $signed(xin[k*DW +: DW]);
    if (m == 2'b10) begin
      e[0] = x[0] + x[3]; e[1] = x[1] + x[2]; e[2] = x[1] - x[2]; e[3] = x[0] - x[3];
      y[0] = e[0] + e[1]; y[1] = 2 * e[3] + e[2]; y[2] = e[0] - e[1]; y[3] = e[3] - 2 * e[2];
    end else begin
      e[0] = x[0] + x[2]; e[1] = x[0] - x[2];
      if (m == 2'b01) begin
        e[2] = x[1] - x[3]; e[3] = x[1] + x[3];
      end else begin
        e[2] = (x[1] >>> 1) - x[3]; e[3] = x[1] + (x[3] >>> 1);
      end
      y[0] = e[0] + e[3]; y[1] = e[1] + e[2]; y[2] = e[1] - e[2]; y[3] = e[0] - e[3];
    end
    for (int k = 0; k < 4; k++) begin
      t = y[k];
`ifdef BUTTERFLY_SAT_EN
      if (t > 32767) t = 32767;
      if (t < -32768) t = -32768;
`endif
      r[k*OW +: OW] = t[OW-1:0];
    end
    return r;
  endfunction

  function automatic beat_t exp_beat(input logic [1:0] m, input logic [IW-1:0] d, input logic [TW-1:0] tg);
    beat_t b;
    b.tag = tg;
    for (int r = 0; r < R; r++) b.data[r*4*OW +: 4*OW] = model_row(m, d[r*4*DW +: 4*DW]);
    return b;
  endfunction

  function automatic logic [4*DW-1:0] pack_in(input int a, input int b, input int c, input int d);
    return {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
  endfunction

  function automatic logic [4*OW-1:0] pack_out(input int a, input int b, input int c, input int d);
    return {d[OW-1:0], c[OW-1:0], b[OW-1:0], a[OW-1:0]};
  endfunction

  function automatic logic [IW-1:0] rand_data();
    logic [IW-1:0] d;
    for (int k = 0; k < R * 4; k++) begin
      case ($urandom_range(0, 4))
        0:       d[k*DW +: DW] = 16'h8000;
        1:       d[k*DW +: DW] = 16'h7fff;
        default: d[k*DW +: DW] = 16'($urandom());
      endcase
    end
    return d;
  endfunction

  // One clock: sample handshake/outputs at negedge, record accepted beats, step past posedge
  task automatic tick();
    @(negedge clk);
    s_acc    = in_valid && in_ready && !rst;
    s_emit   = out_valid && out_ready && !rst;
    s_valid  = out_valid;
    s_valid1 = out_valid1;
    s_ready  = in_ready;
    s_ready1 = in_ready1;
    s_data   = out_data;
    s_data1  = out_data1;
    s_tag    = out_tag;
    s_tag1   = out_tag1;
    if (s_acc) sb.push_back(exp_beat(in_mode, in_data, in_tag));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_tag = '0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    checks++; if (out_tag !== '0) begin failures++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    sb.delete();
  endtask

  task automatic test_inverse();
    beat_t e;
    int n;
    bit got;
    in_valid = 1'b1; in_mode = 2'b00; in_tag = 4'd5; in_data = {R{pack_in(16, 8, 0, 4)}}; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (!s_acc) begin failures++; $display("FAIL inv_accept got=0 want=1"); end
    n = 0; got = 1'b0;
    for (int i = 1; i <= 6 && !got; i++) begin
      tick();
      if (s_emit) begin got = 1'b1; n = i; end
    end
    checks++; if (n != 2) begin failures++; $display("FAIL inv_latency got=%0d want=2", n); end
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (s_data !== {R{pack_out(26, 16, 16, 6)}} || s_tag !== 4'd5) begin
        failures++; $display("FAIL inv_value got=%h tag=%h want=%h tag=5", s_data, s_tag, {R{pack_out(26, 16, 16, 6)}});
      end
      checks++;
      if (s_data !== e.data || s_data1 !== e.data[4*OW-1:0] || s_tag1 !== e.tag) begin
        failures++; $display("FAIL inv_model got=%h/%h want=%h", s_data, s_data1, e.data);
      end
    end
    sb.delete();
  endtask

  task automatic test_modes();
    logic [1:0]    m[10];
    logic [IW-1:0] d[10];
    beat_t e;
    int sent, rcv, cyc, acc_cycles;
    m[0] = 2'b01; d[0] = {R{pack_in(1, 2, 3, 4)}};
    m[1] = 2'b10; d[1] = {R{pack_in(1, 2, 3, 4)}};
    for (int i = 2; i < 10; i++) begin m[i] = 2'(i); d[i] = rand_data(); end
    out_ready = 1'b1; sent = 0; rcv = 0; acc_cycles = 0;
    for (cyc = 0; cyc < 40 && rcv < 10; cyc++) begin
      in_valid = (sent < 10);
      in_mode  = m[sent % 10];
      in_data  = d[sent % 10];
      in_tag   = 4'(sent + 1);
      tick();
      if (s_acc) begin sent++; acc_cycles++; end
      if (s_emit) begin
        if (sb.size() == 0) begin
          checks++; failures++; $display("FAIL modes_extra_beat got=1 want=0");
        end else begin
          e = sb.pop_front();
          checks++;
          if (s_data !== e.data || s_tag !== e.tag || s_data1 !== e.data[4*OW-1:0] || s_tag1 !== e.tag) begin
            failures++; $display("FAIL modes_beat%0d got=%h tag=%h want=%h tag=%h", rcv, s_data, s_tag, e.data, e.tag);
          end
          if (rcv == 0) begin
            checks++;
            if (s_data[4*OW-1:0] !== pack_out(10, -4, 0, -2)) begin
              failures++; $display("FAIL hadamard_value got=%h want=%h", s_data[4*OW-1:0], pack_out(10, -4, 0, -2));
            end
          end
          if (rcv == 1) begin
            checks++;
            if (s_data[4*OW-1:0] !== pack_out(10, -7, 0, -1)) begin
              failures++; $display("FAIL forward_value got=%h want=%h", s_data[4*OW-1:0], pack_out(10, -7, 0, -1));
            end
          end
          rcv++;
        end
      end
    end
    in_valid = 1'b0;
    checks++; if (rcv != 10) begin failures++; $display("FAIL modes_count got=%0d want=10", rcv); end
    // full rate: every beat accepted on consecutive cycles
    checks++; if (acc_cycles != 10) begin failures++; $display("FAIL modes_rate got=%0d want=10", acc_cycles); end
    sb.delete();
  endtask

  task automatic test_back_to_back_stall();
    logic [IW-1:0] d[5];
    logic [XW-1:0] held;
    logic [TW-1:0] held_tag;
    bit have;
    beat_t e;
    int sent, rcv, stall_acc;
    for (int i = 0; i < 5; i++) d[i] = rand_data();
    sent = 0; rcv = 0; have = 1'b0; stall_acc = 0;
    for (int c = 0; c < 30 && rcv < 5; c++) begin
      out_ready = (c >= 4);
      in_valid  = (sent < 5);
      in_mode   = 2'(sent);
      in_data   = d[sent % 5];
      in_tag    = 4'(8 + sent);
      tick();
      if (s_acc) sent++;
      if (c < 4) begin
        if (s_acc) stall_acc++;
        if (s_valid) begin
          if (!have) begin held = s_data; held_tag = s_tag; have = 1'b1; end
          else begin
            checks++;
            if (s_data !== held || s_tag !== held_tag) begin
              failures++; $display("FAIL stall_stable got=%h want=%h", s_data, held);
            end
          end
        end
      end
      if (c == 3) begin
        checks++; if (stall_acc != 2) begin failures++; $display("FAIL stall_accepted got=%0d want=2", stall_acc); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b want=0", s_ready); end
      end
      if (s_emit) begin
        if (sb.size() == 0) begin
          checks++; failures++; $display("FAIL stall_duplicate got=extra want=none");
        end else begin
          e = sb.pop_front();
          checks++;
          if (s_data !== e.data || s_tag !== e.tag || s_data1 !== e.data[4*OW-1:0]) begin
            failures++; $display("FAIL stall_beat%0d got=%h tag=%h want=%h tag=%h", rcv, s_data, s_tag, e.data, e.tag);
          end
          rcv++;
        end
      end
    end
    in_valid = 1'b0;
    repeat (3) tick();
    checks++; if (rcv != 5 || s_valid) begin failures++; $display("FAIL stall_count got=%0d want=5", rcv); end
    sb.delete();
  endtask

  task automatic test_saturation();
    logic [IW-1:0] d[2];
    beat_t e;
    int sent, rcv;
    d[0] = {R{pack_in(32767, 32767, 0, 0)}};
    d[1] = {R{pack_in(-32768, 0, 32767, -32768)}};
    out_ready = 1'b1; sent = 0; rcv = 0;
    for (int c = 0; c < 10 && rcv < 2; c++) begin
      in_valid = (sent < 2); in_mode = 2'b00; in_tag = 4'(sent); in_data = d[sent % 2];
      tick();
      if (s_acc) sent++;
      if (s_emit && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (s_data !== e.data || s_data1 !== e.data[4*OW-1:0]) begin
          failures++; $display("FAIL sat_beat%0d got=%h want=%h", rcv, s_data, e.data);
        end
        rcv++;
      end
    end
    in_valid = 1'b0;
    checks++; if (rcv != 2) begin failures++; $display("FAIL sat_count got=%0d want=2", rcv); end
    sb.delete();
  endtask

  task automatic test_reset_midstream();
    beat_t e;
    int emits, n;
    bit got;
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b01; in_data = rand_data(); in_tag = 4'd3;
    tick();
    in_data = rand_data(); in_tag = 4'd4;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    sb.delete();
    checks++; if (out_valid !== 1'b0 || out_tag !== '0 || out_data !== '0) begin
      failures++; $display("FAIL midrst_outputs got=%b/%h want=0/0", out_valid, out_tag);
    end
    rst = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    emits = 0;
    repeat (4) begin tick(); if (s_valid || s_valid1) emits++; end
    checks++; if (emits != 0) begin failures++; $display("FAIL midrst_ghost got=%0d want=0", emits); end
    in_valid = 1'b1; in_mode = 2'b10; in_data = rand_data(); in_tag = 4'd9;
    tick();
    in_valid = 1'b0;
    n = 0; got = 1'b0;
    for (int i = 1; i <= 6 && !got; i++) begin
      tick();
      if (s_emit) begin got = 1'b1; n = i; end
    end
    checks++; if (n != 2) begin failures++; $display("FAIL midrst_latency got=%0d want=2", n); end
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (s_data !== e.data || s_tag !== e.tag) begin
        failures++; $display("FAIL midrst_value got=%h want=%h", s_data, e.data);
      end
    end
    sb.delete();
  endtask

  task automatic test_random();
    beat_t e;
    int rcv;
    rcv = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_mode   = 2'($urandom_range(0, 3));
      in_tag    = 4'($urandom());
      in_data   = rand_data();
      tick();
      checks++;
      if (s_valid1 !== s_valid || s_ready1 !== s_ready) begin
        failures++; $display("FAIL rand_rows1_handshake got=%b%b want=%b%b", s_valid1, s_ready1, s_valid, s_ready);
      end
      if (s_emit) begin
        if (sb.size() == 0) begin
          checks++; failures++; $display("FAIL rand_extra_beat got=1 want=0");
        end else begin
          e = sb.pop_front();
          checks++;
          if (s_data !== e.data || s_tag !== e.tag || s_data1 !== e.data[4*OW-1:0] || s_tag1 !== e.tag) begin
            failures++; $display("FAIL rand_beat%0d got=%h tag=%h want=%h tag=%h", rcv, s_data, s_tag, e.data, e.tag);
          end
          rcv++;
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (s_emit && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (s_data !== e.data || s_tag !== e.tag) begin
          failures++; $display("FAIL rand_drain got=%h want=%h", s_data, e.data);
        end
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL rand_lost got=%0d want=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_inverse();
    test_modes();
    test_back_to_back_stall();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
